fetch: RTL

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_skid.sv | 40 ++++
 rtl/fetch.sv | 97 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath width,
// the canonical NOP, the default reset vector and the IF/ID entry layout.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST           = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ifid_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for an instruction response that returns while
// the IF/ID register is stalled.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output ifid_t           o_entry
);

    logic            valid_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] pc_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            valid_q <= 1'b0;
        end else if (i_load) begin
            valid_q <= 1'b1;
        end else if (i_drain) begin
            valid_q <= 1'b0;
        end
    end

    // NOTE: payload needs no reset; it is only observed while valid_q is set.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            inst_q <= i_inst;
            pc_q   <= i_pc;
        end
    end

    assign o_entry = '{valid: valid_q, inst: inst_q, pc: pc_q};

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues sequential reads, registers the response
// into IF/ID, and handles stall/redirect. Define FETCH_SKID_EN to add a skid entry.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_id_halt,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_ren,
    output logic [XLEN-1:0] o_imem_raddr,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            req_vld_q;
    logic            issue;
    ifid_t           skid;

    // The issue condition is also the IF/ID load condition.
    assign issue        = !i_if_id_halt && !i_redirect;
    assign o_imem_ren   = issue && !i_rst;
    assign o_imem_raddr = pc_q;

`ifdef FETCH_SKID_EN
    localparam bit SKID_EN = 1'b1;

    logic skid_load;
    logic skid_drain;

    assign skid_load  = i_if_id_halt && !i_redirect && req_vld_q;
    assign skid_drain = issue && skid.valid;

    fetch_skid u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (skid_load),
        .i_drain (skid_drain),
        .i_clear (i_redirect),
        .i_inst  (i_imem_rdata),
        .i_pc    (req_pc_q),
        .o_entry (skid)
    );
`else
    localparam bit SKID_EN = 1'b0;

    assign skid = '0;
`endif

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q      <= RESET_ADDR;
            req_pc_q  <= RESET_ADDR;
            req_vld_q <= 1'b0;
            o_valid   <= 1'b0;
            o_inst    <= NOP_INST;
            o_pc      <= '0;
        end else begin
            req_vld_q <= issue;

            if (issue) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + XLEN'(4);
            end else if (i_redirect) begin
                pc_q <= word_align(i_redirect_pc);
            end else if (!SKID_EN && req_vld_q) begin
                // Stalled with a response landing and nowhere to keep it: refetch it.
                pc_q <= req_pc_q;
            end

            if (i_redirect) begin
                o_valid <= 1'b0;
            end else if (!i_if_id_halt) begin
                if (skid.valid) begin
                    o_valid <= 1'b1;
                    o_inst  <= skid.inst;
                    o_pc    <= skid.pc;
                end else if (req_vld_q) begin
                    o_valid <= 1'b1;
                    o_inst  <= i_imem_rdata;
                    o_pc    <= req_pc_q;
                end else begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule
